instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the instruction-memory capacity in words (1..256).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h00000000, meaning the byte address of the first word written.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 clear  input  1  synchronous restart: address back to BASE_ADDR, count 0, err 0.
REQ-007 in_valid  input  1  request holds a valid instruction description.
REQ-008 in_ready  output  1  block can accept a request this cycle.
REQ-009 op_sel  input  3  0=R-type, 1=LW, 2=SW, 3=BEQ, 4=J, 5=ADDI, 6/7=invalid.
REQ-010 rs, rt, rd, shamt  input  5 each  register and shift fields.
REQ-011 funct  input  6  R-type function field.
REQ-012 imm  input  16  immediate/offset for LW, SW, BEQ, ADDI.
REQ-013 target  input  26  jump target field for J.
REQ-014 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-015 mem_addr  output  32  byte address of the word being written.
REQ-016 mem_wdata  output  32  encoded instruction word.
REQ-017 count  output  9  number of words written since reset/clear.
REQ-018 full  output  1  high when count == DEPTH.
REQ-019 err  output  1  sticky flag: an invalid op_sel was accepted.

Function
REQ-020 The FSM SHALL have two states: IDLE and WRITE; reset state is IDLE.
REQ-021 in_ready SHALL equal (state==IDLE) & ~full & ~clear.
REQ-022 A request SHALL be accepted on a rising edge where in_valid & in_ready; op fields are registered at that edge.
REQ-023 A valid-op acceptance SHALL move IDLE->WRITE; mem_we SHALL be 1 for exactly the following cycle, then WRITE->IDLE unconditionally.
REQ-024 Latency SHALL be one cycle from acceptance edge to mem_we high; throughput is one word per two cycles.
REQ-025 Encoding: R = {6'b000000,rs,rt,rd,shamt,funct}; LW = {6'b100011,rs,rt,imm}; SW = {6'b101011,rs,rt,imm}; BEQ = {6'b000100,rs,rt,imm}; J = {6'b000010,target}; ADDI = {6'b001000,rs,rt,imm}.
REQ-026 An accepted invalid op_sel SHALL be consumed without a write: state stays IDLE, err sets to 1, address and count unchanged.
REQ-027 mem_addr SHALL equal BASE_ADDR + 4*count (32-bit wrap) and be stable while mem_we is high.
REQ-028 At the edge ending the WRITE cycle, count SHALL increment by 1; full SHALL assert when count reaches DEPTH and in_ready SHALL then stay 0 until clear or reset.
REQ-029 clear in IDLE SHALL set count 0 and err 0 at the next edge; clear has priority over a simultaneous in_valid (no acceptance).
REQ-030 clear during WRITE SHALL let the in-progress write complete (mem_we stays 1 that cycle), then set count 0 instead of incrementing.
REQ-031 mem_wdata SHALL be don't-care when mem_we is 0, but SHALL not change during a WRITE cycle.

Reset
REQ-032 reset SHALL asynchronously force state=IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err=0; in_ready=1 after reset deasserts.
REQ-033 reset asserted during WRITE SHALL abort the write immediately (mem_we low in the same cycle) with no count increment.

Verification
REQ-034 R-type rs=8, rt=9, rd=10, shamt=0, funct=0x20 after reset -> one cycle mem_we=1, mem_addr=0x00000000, mem_wdata=0x01095020, count=1.
REQ-035 Back-to-back LW rs=29, rt=8, imm=4 then ADDI rs=0, rt=8, imm=5 with in_valid held high -> writes 0x8FA80004 @0x0, 0x20080005 @0x4, accepts spaced 2 cycles.
REQ-036 BEQ rs=8, rt=9, imm=0xFFFF then J target=0x0000010 -> 0x1109FFFF and 0x08000010 at consecutive addresses.
REQ-037 op_sel=6 accepted -> no mem_we, err=1, count unchanged; next valid op writes at the unchanged address; clear -> err=0.
REQ-038 DEPTH=4, five requests -> four writes, full=1 and in_ready=0 after the fourth; clear -> count=0, next write at BASE_ADDR.
REQ-039 reset pulsed in WRITE cycle -> mem_we drops same cycle, count=0, mem_addr=BASE_ADDR, in_ready=1 after release.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request/instruction-memory bus for instr_encoder.
// master = requester (drives op fields), slave = encoder.
interface instr_encoder_if;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_sel;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;
  logic        full;
  logic        err;

  modport master (
    output clear, in_valid, op_sel, rs, rt, rd, shamt, funct, imm, target,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err
  );

  modport slave (
    input  clear, in_valid, op_sel, rs, rt, rd, shamt, funct, imm, target,
    output in_ready, mem_we, mem_addr, mem_wdata, count, full, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes MIPS-style instruction descriptions into 32-bit words and writes
// them sequentially into an instruction memory starting at BASE_ADDR.
module instr_encoder #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  instr_encoder_if.slave bus
);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e      state_q, state_d;
  logic [8:0]  count_q, count_d;
  logic        err_q, err_d;
  logic [31:0] wdata_q, wdata_d;

  logic        full;
  logic        in_ready;
  logic        accept;
  logic        op_ok;
  logic [31:0] enc;

  always_comb begin
    enc   = '0;
    op_ok = 1'b1;
    case (bus.op_sel)
      3'd0:    enc = {6'b000000, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
      3'd1:    enc = {6'b100011, bus.rs, bus.rt, bus.imm};
      3'd2:    enc = {6'b101011, bus.rs, bus.rt, bus.imm};
      3'd3:    enc = {6'b000100, bus.rs, bus.rt, bus.imm};
      3'd4:    enc = {6'b000010, bus.target};
      3'd5:    enc = {6'b001000, bus.rs, bus.rt, bus.imm};
      default: op_ok = 1'b0;
    endcase
  end

  assign full     = (count_q == 9'(DEPTH));
  assign in_ready = (state_q == IDLE) & ~full & ~bus.clear;
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          count_d = '0;
          err_d   = 1'b0;
        end else if (accept) begin
          if (op_ok) begin
            state_d = WRITE;
            wdata_d = enc;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WRITE: begin
        // The write always completes; clear only redirects the count update.
        state_d = IDLE;
        if (bus.clear) begin
          count_d = '0;
          err_d   = 1'b0;
        end else begin
          count_d = count_q + 9'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
    end
  end

  // mem_we decodes straight from state so reset kills a write in the same cycle.
  assign bus.mem_we    = (state_q == WRITE);
  assign bus.mem_addr  = BASE_ADDR + {21'b0, count_q, 2'b00};
  assign bus.mem_wdata = wdata_q;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.err       = err_q;
  assign bus.in_ready  = in_ready;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench: two encoder instances (default and DEPTH=4 with a
// wrapping base address) share one stimulus and are checked against a model.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_encoder_if if0 ();
  instr_encoder_if if1 ();

  assign if1.clear    = if0.clear;
  assign if1.in_valid = if0.in_valid;
  assign if1.op_sel   = if0.op_sel;
  assign if1.rs       = if0.rs;
  assign if1.rt       = if0.rt;
  assign if1.rd       = if0.rd;
  assign if1.shamt    = if0.shamt;
  assign if1.funct    = if0.funct;
  assign if1.imm      = if0.imm;
  assign if1.target   = if0.target;

  instr_encoder u_d0 (.clk(clk), .reset(reset), .bus(if0.slave));
  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'hFFFF_FFF8)) u_d1 (
    .clk(clk), .reset(reset), .bus(if1.slave));

  int unsigned  dep  [2] = '{64, 4};
  logic [31:0]  base [2] = '{32'h0000_0000, 32'hFFFF_FFF8};

  bit          m_wr  [2];
  int unsigned m_cnt [2];
  bit          m_err [2];
  logic [31:0] m_word[2];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [31:0] ref_word(input int unsigned op);
    logic [31:0] opc [6];
    opc = '{32'd0, 32'd35, 32'd43, 32'd4, 32'd2, 32'd8};
    if (op == 0)
      return 32'(if0.rs) * 32'h0020_0000 + 32'(if0.rt) * 32'h0001_0000 +
             32'(if0.rd) * 32'd2048 + 32'(if0.shamt) * 32'd64 + 32'(if0.funct);
    if (op == 4)
      return opc[4] * 32'h0400_0000 + 32'(if0.target);
    return opc[op] * 32'h0400_0000 + 32'(if0.rs) * 32'h0020_0000 +
           32'(if0.rt) * 32'h0001_0000 + 32'(if0.imm);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wr[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_word[i] = '0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (m_wr[i]) begin
        m_wr[i]  = 0;
        m_cnt[i] = if0.clear ? 0 : m_cnt[i] + 1;
        if (if0.clear) m_err[i] = 0;
      end else if (if0.clear) begin
        m_cnt[i] = 0;
        m_err[i] = 0;
      end else if (if0.in_valid && m_cnt[i] != dep[i]) begin
        if (if0.op_sel <= 3'd5) begin
          m_wr[i]   = 1;
          m_word[i] = ref_word(int'(if0.op_sel));
        end else begin
          m_err[i] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input int i, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [8:0] cnt,
                         input logic full, input logic err, input logic rdy);
    string p;
    bit    exp_full;
    p = (i == 0) ? "d0" : "d1";
    exp_full = (m_cnt[i] == dep[i]);
    chk({p, ".mem_we"},   32'(we),   32'(m_wr[i]));
    chk({p, ".mem_addr"}, addr,      base[i] + 32'(4 * m_cnt[i]));
    chk({p, ".count"},    32'(cnt),  32'(m_cnt[i]));
    chk({p, ".full"},     32'(full), 32'(exp_full));
    chk({p, ".err"},      32'(err),  32'(m_err[i]));
    chk({p, ".in_ready"}, 32'(rdy),  32'(!m_wr[i] && !exp_full && !if0.clear));
    if (m_wr[i]) chk({p, ".mem_wdata"}, wdata, m_word[i]);
  endtask

  task automatic check_all();
    chk_dut(0, if0.mem_we, if0.mem_addr, if0.mem_wdata, if0.count, if0.full, if0.err, if0.in_ready);
    chk_dut(1, if1.mem_we, if1.mem_addr, if1.mem_wdata, if1.count, if1.full, if1.err, if1.in_ready);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_req(input int unsigned op, input int unsigned rs, input int unsigned rt,
                         input int unsigned rd, input int unsigned sh, input int unsigned fn,
                         input int unsigned imm, input int unsigned tg);
    if0.op_sel = 3'(op);  if0.rs = 5'(rs);     if0.rt = 5'(rt);   if0.rd = 5'(rd);
    if0.shamt  = 5'(sh);  if0.funct = 6'(fn);  if0.imm = 16'(imm); if0.target = 26'(tg);
  endtask

  task automatic reset_mid_cycle();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_wdata", if0.mem_wdata, 32'h0);
    #1;
    reset = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1;
    if0.clear = 1'b0;
    if0.in_valid = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    model_reset();
    check_all();
    chk("rst_wdata", if0.mem_wdata, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(if0.in_ready), 32'd1);

    // R-type after reset
    set_req(0, 8, 9, 10, 0, 6'h20, 0, 0);
    if0.in_valid = 1'b1;
    cycle();
    if0.in_valid = 1'b0;
    chk("r_word", if0.mem_wdata, 32'h0109_5020);
    chk("r_addr", if0.mem_addr, 32'h0);
    cycle();
    chk("r_count", 32'(if0.count), 32'd1);
    if0.clear = 1'b1;
    cycle();
    if0.clear = 1'b0;

    // LW then ADDI with valid held high
    set_req(1, 29, 8, 0, 0, 0, 4, 0);
    if0.in_valid = 1'b1;
    cycle();
    set_req(5, 0, 8, 0, 0, 0, 5, 0);
    chk("lw_word", if0.mem_wdata, 32'h8FA8_0004);
    chk("lw_addr", if0.mem_addr, 32'h0);
    cycle();
    chk("gap_we", 32'(if0.mem_we), 32'd0);
    cycle();
    chk("addi_word", if0.mem_wdata, 32'h2008_0005);
    chk("addi_addr", if0.mem_addr, 32'h4);

    // BEQ then J
    set_req(3, 8, 9, 0, 0, 0, 16'hFFFF, 0);
    cycle();
    cycle();
    set_req(4, 0, 0, 0, 0, 0, 0, 26'h10);
    chk("beq_word", if0.mem_wdata, 32'h1109_FFFF);
    chk("beq_addr", if0.mem_addr, 32'h8);
    cycle();
    cycle();
    if0.in_valid = 1'b0;
    chk("j_word", if0.mem_wdata, 32'h0800_0010);
    chk("j_addr", if0.mem_addr, 32'hC);
    cycle();

    // invalid op: consumed, sticky err, no write
    set_req(6, 1, 2, 3, 4, 5, 6, 7);
    if0.in_valid = 1'b1;
    cycle();
    if0.in_valid = 1'b0;
    chk("inv_err", 32'(if0.err), 32'd1);
    chk("inv_we", 32'(if0.mem_we), 32'd0);
    set_req(0, 1, 2, 3, 0, 6'h22, 0, 0);
    if0.in_valid = 1'b1;
    cycle();
    if0.in_valid = 1'b0;
    chk("inv_next_addr", if0.mem_addr, 32'h10);
    cycle();
    if0.clear = 1'b1;
    cycle();
    if0.clear = 1'b0;
    chk("clr_err", 32'(if0.err), 32'd0);

    // fill the DEPTH=4 instance with five requests
    set_req(2, 3, 4, 0, 0, 0, 16'h1234, 0);
    if0.in_valid = 1'b1;
    repeat (10) cycle();
    if0.in_valid = 1'b0;
    chk("d1_full", 32'(if1.full), 32'd1);
    chk("d1_ready", 32'(if1.in_ready), 32'd0);
    chk("d1_count", 32'(if1.count), 32'd4);
    if0.clear = 1'b1;
    cycle();
    if0.clear = 1'b0;
    if0.in_valid = 1'b1;
    cycle();
    if0.in_valid = 1'b0;
    chk("d1_base", if1.mem_addr, 32'hFFFF_FFF8);
    cycle();

    // clear during WRITE lets the write finish
    if0.in_valid = 1'b1;
    cycle();
    if0.in_valid = 1'b0;
    if0.clear = 1'b1;
    chk("clrw_we", 32'(if0.mem_we), 32'd1);
    cycle();
    if0.clear = 1'b0;
    chk("clrw_count", 32'(if0.count), 32'd0);

    // clear beats simultaneous valid
    if0.in_valid = 1'b1;
    if0.clear = 1'b1;
    cycle();
    if0.in_valid = 1'b0;
    if0.clear = 1'b0;
    chk("clrv_we", 32'(if0.mem_we), 32'd0);

    // reset during WRITE aborts immediately
    cycle();
    if0.in_valid = 1'b1;
    cycle();
    if0.in_valid = 1'b0;
    chk("rstw_pre_we", 32'(if0.mem_we), 32'd1);
    reset_mid_cycle();
    chk("rstw_we", 32'(if0.mem_we), 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      set_req($urandom_range(7), $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom);
      if0.in_valid = ($urandom_range(3) != 0);
      if0.clear    = ($urandom_range(15) == 0);
      cycle();
      if ($urandom_range(63) == 0) reset_mid_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
